// File: rtl/z80_bus_ctrl.sv
// Z80 CPU-side bus cycle sequencer: turns single-cycle core requests into registered T-state strobe sequences.
// Latency: fetch 4 clocks, read/write 3 clocks, plus one per wait state; done pulses the clock after the last T-state.
// Backpressure: req_ready only in IDLE or the final T-state; WAIT_L stretches T2 via TW. Optional bus grant: Z80_BUSREQ_EN.
module z80_bus_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int R_BITS = 7
) (
    input  logic              clk,
    input  logic              rst_L,
    input  logic              req,
    input  logic [1:0]        req_type,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    input  logic [7:0]        i_reg,
    input  logic              r_load,
    input  logic [7:0]        r_wdata,
    output logic [7:0]        r_reg,
    input  logic              WAIT_L,
    output logic              MREQ_L,
    output logic              RD_L,
    output logic              WR_L,
    output logic              M1_L,
    output logic              RFSH_L,
    output logic [ADDR_W-1:0] addr_bus,
`ifdef Z80_BUSREQ_EN
    input  logic              BUSREQ_L,
    output logic              BUSACK_L,
`endif
    inout  wire  [DATA_W-1:0] data_bus
);

    localparam logic [1:0] TYPE_FETCH = 2'b00;
    localparam logic [1:0] TYPE_READ  = 2'b01;
    localparam logic [1:0] TYPE_WRITE = 2'b10;
    localparam logic [1:0] TYPE_RSVD  = 2'b11;

    // Bits of R that take part in the refresh counter; the rest are held.
    localparam logic [7:0] R_MASK = 8'((16'd1 << R_BITS) - 16'd1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_T1     = 3'd1,
        S_T2     = 3'd2,
        S_TW     = 3'd3,
        S_T3     = 3'd4,
        S_T4     = 3'd5
`ifdef Z80_BUSREQ_EN
        , S_BUSACK = 3'd6
`endif
    } state_t;

    state_t r_state;
    state_t w_next;
    state_t w_end_next;

    // Request captured at acceptance so the core may move on.
    logic [1:0]        r_type;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_req_wdata;

    // Registered bus-side outputs.
    logic              r_mreq_l;
    logic              r_rd_l;
    logic              r_wr_l;
    logic              r_m1_l;
    logic              r_rfsh_l;
    logic [ADDR_W-1:0] r_addr_bus;
    logic [DATA_W-1:0] r_dout;
    logic              r_dout_en;
    logic              r_done;
    logic [DATA_W-1:0] r_rdata;

    logic              w_final;
    logic              w_ready;
    logic              w_accept;
    logic              w_capture;
    logic [1:0]        w_n_type;
    logic [ADDR_W-1:0] w_n_addr;
    logic [DATA_W-1:0] w_n_wdata;
    logic [15:0]       w_ir;
    logic [ADDR_W-1:0] w_rfsh_addr;
    logic [7:0]        w_r_inc;

    logic              w_n_mreq_l;
    logic              w_n_rd_l;
    logic              w_n_wr_l;
    logic              w_n_m1_l;
    logic              w_n_rfsh_l;
    logic              w_n_dout_en;
    logic [ADDR_W-1:0] w_n_addr_bus;

    // The last T-state is T4 for a fetch and T3 for read/write.
    assign w_final   = (r_state == S_T4) || ((r_state == S_T3) && (r_type != TYPE_FETCH));
    assign w_ready   = (r_state == S_IDLE) || w_final;
    assign req_ready = w_ready;

`ifdef Z80_BUSREQ_EN
    // A pending bus request wins over a simultaneous core request.
    assign w_accept = req && w_ready && (req_type != TYPE_RSVD) && BUSREQ_L;
`else
    assign w_accept = req && w_ready && (req_type != TYPE_RSVD);
`endif

    // Attributes of the cycle that will be on the bus after this edge.
    assign w_n_type  = w_accept ? req_type  : r_type;
    assign w_n_addr  = w_accept ? req_addr  : r_addr;
    assign w_n_wdata = w_accept ? req_wdata : r_req_wdata;

    assign w_ir        = {i_reg, r_reg};
    assign w_rfsh_addr = ADDR_W'(w_ir);
    assign w_r_inc     = (r_reg & ~R_MASK) | ((r_reg + 8'd1) & R_MASK);

    // Fetch samples the bus leaving the last T2/TW; read samples leaving T3.
    assign w_capture = ((r_type == TYPE_FETCH) && ((r_state == S_T2) || (r_state == S_TW)) && (w_next == S_T3))
                    || ((r_type == TYPE_READ) && (r_state == S_T3));

    // Where to go after IDLE or a final T-state: new cycle, bus grant, or idle.
    always_comb begin
        w_end_next = w_accept ? S_T1 : S_IDLE;
`ifdef Z80_BUSREQ_EN
        if (!BUSREQ_L) begin
            w_end_next = S_BUSACK;
        end
`endif
    end

    // Next T-state; WAIT_L only matters leaving T2 or TW.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_end_next;
            S_T1:    w_next = S_T2;
            S_T2,
            S_TW:    w_next = WAIT_L ? S_T3 : S_TW;
            S_T3:    w_next = (r_type == TYPE_FETCH) ? S_T4 : w_end_next;
            S_T4:    w_next = w_end_next;
`ifdef Z80_BUSREQ_EN
            S_BUSACK: w_next = BUSREQ_L ? S_IDLE : S_BUSACK;
`endif
            default: w_next = S_IDLE;
        endcase
    end

    // Strobe/address/data values to be held during the next T-state.
    always_comb begin
        w_n_mreq_l   = 1'b1;
        w_n_rd_l     = 1'b1;
        w_n_wr_l     = 1'b1;
        w_n_m1_l     = 1'b1;
        w_n_rfsh_l   = 1'b1;
        w_n_dout_en  = 1'b0;
        w_n_addr_bus = r_addr_bus;
        case (w_next)
            S_T1, S_T2, S_TW: begin
                w_n_mreq_l   = 1'b0;
                w_n_addr_bus = w_n_addr;
                w_n_rd_l     = (w_n_type == TYPE_WRITE);
                w_n_m1_l     = (w_n_type != TYPE_FETCH);
                w_n_wr_l     = !((w_n_type == TYPE_WRITE) && (w_next != S_T1));
                w_n_dout_en  = (w_n_type == TYPE_WRITE);
            end
            S_T3, S_T4: begin
                w_n_mreq_l = 1'b0;
                if (w_n_type == TYPE_FETCH) begin
                    w_n_rfsh_l   = 1'b0;
                    w_n_addr_bus = w_rfsh_addr;
                end else begin
                    w_n_addr_bus = w_n_addr;
                    w_n_rd_l     = (w_n_type != TYPE_READ);
                    w_n_wr_l     = (w_n_type != TYPE_WRITE);
                    w_n_dout_en  = (w_n_type == TYPE_WRITE);
                end
            end
            default: begin
                w_n_mreq_l = 1'b1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Latch the request on acceptance.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_type      <= TYPE_FETCH;
            r_addr      <= '0;
            r_req_wdata <= '0;
        end else if (w_accept) begin
            r_type      <= req_type;
            r_addr      <= req_addr;
            r_req_wdata <= req_wdata;
        end
    end

    // Register the bus strobes, address and write-data drive.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_mreq_l   <= 1'b1;
            r_rd_l     <= 1'b1;
            r_wr_l     <= 1'b1;
            r_m1_l     <= 1'b1;
            r_rfsh_l   <= 1'b1;
            r_addr_bus <= '0;
            r_dout     <= '0;
            r_dout_en  <= 1'b0;
        end else begin
            r_mreq_l   <= w_n_mreq_l;
            r_rd_l     <= w_n_rd_l;
            r_wr_l     <= w_n_wr_l;
            r_m1_l     <= w_n_m1_l;
            r_rfsh_l   <= w_n_rfsh_l;
            r_addr_bus <= w_n_addr_bus;
            r_dout     <= w_n_wdata;
            r_dout_en  <= w_n_dout_en;
        end
    end

    // Completion pulse and read-data capture.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_done  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_done <= w_final;
            if (w_capture) begin
                r_rdata <= data_bus;
            end
        end
    end

    // R register: core load beats the end-of-fetch increment.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_reg <= 8'h00;
        end else if (r_load) begin
            r_reg <= r_wdata;
        end else if (r_state == S_T4) begin
            r_reg <= w_r_inc;
        end
    end

    assign done     = r_done;
    assign rdata    = r_rdata;
    assign data_bus = r_dout_en ? r_dout : {DATA_W{1'bz}};

`ifdef Z80_BUSREQ_EN
    logic r_busack;

    // Bus grant flag, held for exactly the BUSACK state.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_busack <= 1'b0;
        end else begin
            r_busack <= (w_next == S_BUSACK);
        end
    end

    assign BUSACK_L = !r_busack;
    assign MREQ_L   = r_busack ? 1'bz : r_mreq_l;
    assign RD_L     = r_busack ? 1'bz : r_rd_l;
    assign WR_L     = r_busack ? 1'bz : r_wr_l;
    assign M1_L     = r_busack ? 1'bz : r_m1_l;
    assign RFSH_L   = r_busack ? 1'bz : r_rfsh_l;
    assign addr_bus = r_busack ? {ADDR_W{1'bz}} : r_addr_bus;
`else
    assign MREQ_L   = r_mreq_l;
    assign RD_L     = r_rd_l;
    assign WR_L     = r_wr_l;
    assign M1_L     = r_m1_l;
    assign RFSH_L   = r_rfsh_l;
    assign addr_bus = r_addr_bus;
`endif

endmodule

// File: doc/z80_bus_ctrl.md
Name: z80_bus_ctrl

Overview:
- CPU-side Z80 bus cycle sequencer; upstream of the memory model on the shared data_bus/addr_bus.
- Converts single-cycle core requests (opcode fetch, memory read, memory write) into T-state-accurate MREQ_L/RD_L/WR_L/M1_L/RFSH_L sequences.
- Inserts wait states from WAIT_L and runs the fetch refresh cycle.
- Returns read data and a done pulse to the core.

Parameters:
- ADDR_W, 16, address bus width.
- DATA_W, 8, data bus width.
- R_BITS, 7, low R-register bits incremented per fetch; bit 7 is held.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst_L  input  1  asynchronous active-low reset.
- req  input  1  core request strobe; accepted when req && req_ready.
- req_type  input  2  00 = fetch (M1), 01 = read, 10 = write, 11 = reserved (ignored, not accepted).
- req_addr  input  ADDR_W  cycle address.
- req_wdata  input  DATA_W  write data.
- req_ready  output  1  high in IDLE and in the final T-state of a cycle.
- done  output  1  one-cycle pulse after a cycle's final T-state.
- rdata  output  DATA_W  captured read/fetch data; valid while done is high, held until the next capture.
- i_reg  input  8  I register, driven onto addr high byte during refresh.
- r_load  input  1  loads R from r_wdata; takes priority over the auto-increment.
- r_wdata  input  8  R load value.
- r_reg  output  8  current R register.
- WAIT_L  input  1  active-low wait request.
- MREQ_L, RD_L, WR_L, M1_L, RFSH_L  output  1 each  active-low bus strobes, registered.
- addr_bus  output  ADDR_W  registered address.
- data_bus  inout  DATA_W  driven only during write T1–T3; hi-z otherwise.

Behaviour:
- Reset (async): state=IDLE; MREQ_L, RD_L, WR_L, M1_L, RFSH_L=1; addr_bus=0; data_bus=Z; done=0; rdata=0; r_reg=0.
- Reset asserted mid-cycle aborts the cycle immediately; no done pulse is produced.
- States: IDLE, T1, T2, TW, T3, T4. All outputs are registered; values below are those held during each state.
- Fetch:
  - T1, T2, TW: addr=req_addr; MREQ_L=RD_L=M1_L=0.
  - rdata captured at the posedge leaving the last T2/TW.
  - T3, T4: addr={i_reg, r_reg}; MREQ_L=0, RD_L=1, M1_L=1, RFSH_L=0.
  - At the end of T4, r_reg[R_BITS-1:0] increments (wraps); r_reg[7] is unchanged.
  - 4 clocks with no waits.
- Read:
  - T1, T2, TW, T3: addr=req_addr; MREQ_L=RD_L=0.
  - rdata captured at the posedge leaving T3.
  - 3 clocks with no waits.
- Write:
  - T1: addr valid, MREQ_L=0, data_bus=req_wdata.
  - T2, TW, T3: WR_L=0 in addition.
  - data_bus is released on the posedge leaving T3.
  - 3 clocks with no waits.
- Wait states:
  - WAIT_L is sampled at the posedge leaving T2 or TW. If low, next state is TW; otherwise T3.
  - No wait-state limit.
  - WAIT_L is ignored in all other states.
- Request acceptance:
  - Inputs are latched into internal registers on acceptance; core inputs may change afterwards.
  - Accepted in IDLE → T1 next clock.
  - Accepted in the final T-state → T1 follows with no idle gap.
  - No request in the final T-state → IDLE, with all strobes deasserted.
- done pulses exactly one cycle after each completed cycle; this may coincide with the next T1.
- Simultaneous r_load and end-of-T4: r_load wins; the increment is dropped.
- req_type=11: req_ready stays high, state is unchanged, no bus activity.

Optional Feature:
- Macro: Z80_BUSREQ_EN.
- When defined, adds ports BUSREQ_L (input) and BUSACK_L (output), and a BUSACK state.
- BUSREQ_L is sampled in IDLE and in the final T-state. If low and no new cycle is accepted, the block enters BUSACK:
  - BUSACK_L=0; addr_bus, data_bus and all strobes hi-z; req_ready=0.
  - Returns to IDLE the clock after BUSREQ_L rises.
  - BUSREQ_L takes priority over a simultaneous req.
- When undefined: ports absent, no BUSACK state, addr_bus and strobes are never hi-z.

Test Plan:
- Fetch, addr=0x0000, memory returns 0x2A, i_reg=0x12, r_reg=0x05 → M1_L low 2 clocks; RFSH_L low 2 clocks with addr=0x1205; rdata=0x2A with done; r_reg=0x06.
- Read addr=0x00BC, memory byte 0xBE → MREQ_L/RD_L low 3 clocks; done in the 4th clock; rdata=0xBE.
- Write addr=0x0010, wdata=0x5A, then read 0x0010 → WR_L low 2 clocks; data_bus hi-z after T3; read returns 0x5A.
- Read with WAIT_L held low for 3 samples → exactly 3 TW states; total 6 clocks to done; rdata correct.
- Back-to-back read then fetch with req held → second T1 immediately follows the first T3; two done pulses; r_reg=0x7F wraps to 0x00 with bit 7 kept.
- Reset pulsed during write T2 → all strobes 1 and data_bus Z immediately; no done; next req starts cleanly at T1.
